inst_mem_loader: RTL and testbench

- Boot-time writer for the CPU's instruction memory.
- Accepts a byte stream from a host link over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into instruction memory through a dedicated write port, holding the CPU in reset until the image is complete.
- Sits beside the CPU top and drives the CPU's reset input.

---
 rtl/inst_mem_loader.sv | 153 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them into
// instruction memory and holds the CPU in reset until done. Optional checksum: INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [31:0]       imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  length_reg;
    logic [23:0]       assemble_reg;
    logic [1:0]        byte_cnt_reg;
    logic [ADDR_W-1:0] word_index_reg;
    logic [ADDR_W:0]   words_loaded_reg;
    logic [31:0]       waddr_reg;
    logic [31:0]       wdata_reg;

    logic              xfer;
    logic [LEN_W-1:0]  len_rx;
    logic [ADDR_W:0]   wl_inc;

    assign in_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                      (state_reg == S_DATA)   || (state_reg == S_CHECK);
    assign xfer     = in_valid && in_ready;
    assign len_rx   = {length_reg[LEN_W-1:8], in_data};
    assign wl_inc   = words_loaded_reg + 1'b1;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_reg;
    logic [7:0] sum_chk;
    assign sum_chk = checksum_reg + in_data;
    localparam state_t S_END = S_CHECK;
`else
    localparam state_t S_END = S_DONE;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_LEN_HI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LEN_HI: if (xfer) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_rx == '0)
                        state_next = S_END;
                    else if (32'(len_rx) > MAX_WORDS)
                        state_next = S_ERROR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA:  if (xfer && byte_cnt_reg == 2'd3) state_next = S_WRITE;
            S_WRITE: state_next = (32'(wl_inc) == 32'(length_reg)) ? S_END : S_DATA;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            S_CHECK: if (xfer) state_next = (sum_chk == 8'd0) ? S_DONE : S_ERROR;
`endif
            S_DONE, S_ERROR: if (reload) state_next = S_LEN_HI;
            default: state_next = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            length_reg       <= '0;
            assemble_reg     <= '0;
            byte_cnt_reg     <= '0;
            word_index_reg   <= '0;
            words_loaded_reg <= '0;
            waddr_reg        <= '0;
            wdata_reg        <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            checksum_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                S_LEN_HI: if (xfer) length_reg[LEN_W-1:8] <= in_data;
                S_LEN_LO: if (xfer) length_reg[7:0] <= in_data;
                S_DATA: begin
                    if (xfer) begin
                        assemble_reg <= {assemble_reg[15:0], in_data};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                        checksum_reg <= sum_chk;
`endif
                        // Latch the full word and its address so they hold after WRITE.
                        if (byte_cnt_reg == 2'd3) begin
                            wdata_reg <= {assemble_reg, in_data};
                            waddr_reg <= {{(30-ADDR_W){1'b0}}, word_index_reg, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    word_index_reg   <= word_index_reg + 1'b1;
                    words_loaded_reg <= wl_inc;
                end
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        length_reg       <= '0;
                        assemble_reg     <= '0;
                        byte_cnt_reg     <= '0;
                        word_index_reg   <= '0;
                        words_loaded_reg <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                        checksum_reg     <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we      = (state_reg == S_WRITE);
    assign imem_waddr   = waddr_reg;
    assign imem_wdata   = wdata_reg;
    assign done         = (state_reg == S_DONE);
    assign error        = (state_reg == S_ERROR);
    assign cpu_reset    = (state_reg != S_DONE);
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; write-port activity is logged at the falling edge.
`timescale 1ns/1ps
module tb_inst_mem_loader;

    localparam int ADDR_W = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      in_data = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            reload = 1'b0;
    logic            imem_we;
    logic [31:0]     imem_waddr;
    logic [31:0]     imem_wdata;
    logic            cpu_reset;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_low_cnt = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    inst_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    always @(negedge clock) begin
        if (imem_we) begin
            log_addr.push_back(imem_waddr);
            log_data.push_back(imem_wdata);
            check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        end
        if (!reset && !in_ready && !done && !error) ready_low_cnt++;
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("send_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // After the last data byte the DUT is in WRITE; close the frame.
    task automatic finish_frame(input logic [7:0] ck);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        send_byte(ck);
`else
        tick();
`endif
    endtask

    logic [7:0] stream [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                8'hAC, 8'h09, 8'h00, 8'h04};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        tick();
        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_waddr", imem_waddr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Two-word frame, in_valid held high
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        check("w0_we", {31'd0, imem_we}, 32'd1);
        check("w0_addr", imem_waddr, 32'h0);
        check("w0_data", imem_wdata, 32'h20080005);
        check("w0_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 6; i < 10; i++) send_byte(stream[i]);
        check("w1_addr", imem_waddr, 32'h4);
        check("w1_data", imem_wdata, 32'hAC090004);
        finish_frame(8'h1A);
        check("two_done", {31'd0, done}, 32'd1);
        check("two_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("two_words", 32'(words_loaded), 32'd2);
        check("two_nwrites", 32'(log_addr.size()), 32'd2);
        check("two_addr_hold", imem_waddr, 32'h4);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) tick();
        in_valid = 1'b0;
        check("done_ignores_bytes", 32'(words_loaded), 32'd2);
        check("done_ready", {31'd0, in_ready}, 32'd0);

        pulse_reload();
        check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_words", 32'(words_loaded), 32'd0);
        check("reload_ready", {31'd0, in_ready}, 32'd1);

        // Same frame with gaps; a stray reload mid-load must be ignored
        base = log_addr.size();
        ready_low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send_byte(stream[i]);
            if (i == 3) pulse_reload();
            else tick();
        end
        finish_frame(8'h1A);
        check("gap_done", {31'd0, done}, 32'd1);
        check("gap_nwrites", 32'(log_addr.size() - base), 32'd2);
        check("gap_a0", log_addr[base], 32'h0);
        check("gap_d0", log_data[base], 32'h20080005);
        check("gap_a1", log_addr[base+1], 32'h4);
        check("gap_d1", log_data[base+1], 32'hAC090004);
        check("gap_ready_low_cycles", 32'(ready_low_cnt), 32'd2);

        // Zero-length frame
        pulse_reload();
        base = log_addr.size();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        check("zero_check_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h00);
`endif
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_nwrites", 32'(log_addr.size() - base), 32'd0);
        check("zero_words", 32'(words_loaded), 32'd0);

        // Oversize frame (257 words)
        pulse_reload();
        send_byte(8'h01);
        send_byte(8'h01);
        check("over_error", {31'd0, error}, 32'd1);
        check("over_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("over_ready", {31'd0, in_ready}, 32'd0);
        check("over_nwrites", 32'(log_addr.size() - base), 32'd0);
        pulse_reload();
        check("over_reload_error", {31'd0, error}, 32'd0);
        check("over_reload_ready", {31'd0, in_ready}, 32'd1);

        // Exactly 256 words is legal; reset after two data bytes
        send_byte(8'h01);
        send_byte(8'h00);
        check("max_len_no_error", {31'd0, error}, 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_rst_nwrites", 32'(log_addr.size() - base), 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("fresh_addr", imem_waddr, 32'h0);
        check("fresh_data", imem_wdata, 32'hDEADBEEF);
        // DE+AD+BE+EF = 0x338 -> 0x38; complement 0xC8
        finish_frame(8'hC8);
        check("fresh_done", {31'd0, done}, 32'd1);
        check("fresh_words", 32'(words_loaded), 32'd1);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
        pulse_reload();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF6);
        check("ck_good_done", {31'd0, done}, 32'd1);
        pulse_reload();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF5);
        check("ck_bad_error", {31'd0, error}, 32'd1);
        check("ck_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
